// File: rtl/pipe_exmem_elastic_pkg.sv
// -----------------------------------------------------------------------------
// loopyV_data_types
// Shared types and constants for the EX/MEM pipeline boundary:
//   - WB_SEL_*   writeback source encodings (ex_dest_sel / mem_dest_sel)
//   - FUNCT3_*   load/store width encodings (ex_ls_sel / mem_ls_sel)
//   - exmem_state_e  occupancy state of the EX/MEM elastic buffer
//   - exmem_t        one EX/MEM payload entry, width set by EXMEM_XLEN
//   - EXMEM_RESET    payload value held by every entry after reset
// -----------------------------------------------------------------------------
package loopyV_data_types;

   parameter int unsigned EXMEM_XLEN = 32;

   localparam logic [1:0] WB_SEL_ALU     = 2'd0;
   localparam logic [1:0] WB_SEL_IMM     = 2'd1;
   localparam logic [1:0] WB_SEL_PC_STEP = 2'd2;
   localparam logic [1:0] WB_SEL_MEM     = 2'd3;

   localparam logic [2:0] FUNCT3_BYTE    = 3'b000;
   localparam logic [2:0] FUNCT3_HALF    = 3'b001;
   localparam logic [2:0] FUNCT3_WORD    = 3'b010;
   localparam logic [2:0] FUNCT3_DOUBLE  = 3'b011;
   localparam logic [2:0] FUNCT3_BYTE_U  = 3'b100;
   localparam logic [2:0] FUNCT3_HALF_U  = 3'b101;
   localparam logic [2:0] FUNCT3_WORD_U  = 3'b110;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } exmem_state_e;

   typedef struct packed {
      logic                  load;
      logic                  store;
      logic                  rd_we;
      logic [2:0]            ls_sel;
      logic [1:0]            dest_sel;
      logic [4:0]            rd_addr;
      logic [EXMEM_XLEN-1:0] wdata;
      logic [EXMEM_XLEN-1:0] store_data;
      logic [EXMEM_XLEN-1:0] pc;
   } exmem_t;

   localparam exmem_t EXMEM_RESET = '{
      load:       1'b0,
      store:      1'b0,
      rd_we:      1'b0,
      ls_sel:     FUNCT3_BYTE,
      dest_sel:   WB_SEL_ALU,
      rd_addr:    5'd0,
      wdata:      '0,
      store_data: '0,
      pc:         '0
   };

endpackage

// File: rtl/pipe_exmem_elastic_wb_select.sv
// -----------------------------------------------------------------------------
// exmem_wb_select
// Combinational writeback-data select ahead of the EX/MEM register.
//   dest_sel   in  2     WB_SEL_* source select
//   compressed in  1     instruction is 16-bit (PC step PC_STEP_C, else 4)
//   alu        in  XLEN  ALU result (also the data-memory address for MEM)
//   imm        in  XLEN  immediate
//   pc         in  XLEN  instruction PC
//   wdata      out XLEN  selected value; PC step wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
module exmem_wb_select
   import loopyV_data_types::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PC_STEP_C = 2
) (
   input  logic [1:0]      dest_sel,
   input  logic            compressed,
   input  logic [XLEN-1:0] alu,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] pc_step;

   assign pc_step = compressed ? XLEN'(PC_STEP_C) : XLEN'(4);

   always_comb begin
      wdata = alu;
      case (dest_sel)
         WB_SEL_ALU:     wdata = alu;
         WB_SEL_IMM:     wdata = imm;
         WB_SEL_PC_STEP: wdata = pc + pc_step;
         // MEM writeback forwards the address; the load data joins later.
         WB_SEL_MEM:     wdata = alu;
         default:        wdata = alu;
      endcase
   end

endmodule

// File: rtl/pipe_exmem_elastic.sv
// -----------------------------------------------------------------------------
// pipe_exmem_elastic
// Elastic EX/MEM pipeline register with valid/ready handshakes.
// Build option EXMEM_SKID_EN:
//   defined   - two-entry skid buffer, ex_ready registered (state != FULL),
//               full throughput without a mem_ready -> ex_ready path
//   undefined - single entry, ex_ready = !mem_valid || mem_ready
// Ports:
//   clk, arstn (async, active-low), flush (sync kill of held entries)
//   ex_valid/ex_ready          upstream handshake
//   ex_* control and operands  EX-stage payload
//   mem_valid/mem_ready        downstream handshake
//   mem_* outputs              registered payload; mem_wdata is the selected
//                              writeback value, mem_dm_addr mirrors it
// -----------------------------------------------------------------------------
module pipe_exmem_elastic
   import loopyV_data_types::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PC_STEP_C = 2
) (
   input  logic            clk,
   input  logic            arstn,
   input  logic            flush,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic            ex_load,
   input  logic            ex_store,
   input  logic            ex_rd_we,
   input  logic [2:0]      ex_ls_sel,
   input  logic [1:0]      ex_dest_sel,
   input  logic            ex_compressed,
   input  logic [XLEN-1:0] ex_alu,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [4:0]      ex_rd_addr,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic            mem_load,
   output logic            mem_store,
   output logic            mem_rd_we,
   output logic [2:0]      mem_ls_sel,
   output logic [1:0]      mem_dest_sel,
   output logic [4:0]      mem_rd_addr,
   output logic [XLEN-1:0] mem_store_data,
   output logic [XLEN-1:0] mem_pc,
   output logic [XLEN-1:0] mem_wdata,
   output logic [XLEN-1:0] mem_dm_addr
);

   logic [XLEN-1:0] wdata_p0;
   exmem_t          in_p0;
   exmem_t          head_p1;
   exmem_state_e    state_p1;
   exmem_state_e    state_nxt;
   logic            in_xfer;
   logic            out_xfer;
   logic            load_head;
`ifdef EXMEM_SKID_EN
   exmem_t          tail_p1;
   logic            load_tail;
   logic            head_from_tail;
`endif

   // ---- stage p0: writeback select and payload assembly ----
   exmem_wb_select #(
      .XLEN      (XLEN),
      .PC_STEP_C (PC_STEP_C)
   ) u_wb_select (
      .dest_sel   (ex_dest_sel),
      .compressed (ex_compressed),
      .alu        (ex_alu),
      .imm        (ex_imm),
      .pc         (ex_pc),
      .wdata      (wdata_p0)
   );

   always_comb begin
      in_p0            = EXMEM_RESET;
      in_p0.load       = ex_load;
      in_p0.store      = ex_store;
      in_p0.rd_we      = ex_rd_we;
      in_p0.ls_sel     = ex_ls_sel;
      in_p0.dest_sel   = ex_dest_sel;
      in_p0.rd_addr    = ex_rd_addr;
      in_p0.wdata      = wdata_p0;
      in_p0.store_data = ex_store_data;
      in_p0.pc         = ex_pc;
   end

   // ---- handshake and occupancy control ----
   assign mem_valid = (state_p1 != ST_EMPTY);
`ifdef EXMEM_SKID_EN
   // Depends only on registered state, so no combinational ready chain.
   assign ex_ready  = (state_p1 != ST_FULL);
`else
   assign ex_ready  = !mem_valid || mem_ready;
`endif
   assign in_xfer   = ex_valid && ex_ready;
   assign out_xfer  = mem_valid && mem_ready;

   always_comb begin
      state_nxt      = state_p1;
      load_head      = 1'b0;
`ifdef EXMEM_SKID_EN
      load_tail      = 1'b0;
      head_from_tail = 1'b0;
`endif
      // flush wins over a same-cycle in-transfer: that beat is dropped.
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_p1)
            ST_EMPTY: begin
               if (in_xfer) begin
                  load_head = 1'b1;
                  state_nxt = ST_BUSY;
               end
            end
            ST_BUSY: begin
`ifdef EXMEM_SKID_EN
               if (in_xfer && out_xfer) begin
                  load_head = 1'b1;
               end else if (in_xfer) begin
                  load_tail = 1'b1;
                  state_nxt = ST_FULL;
               end else if (out_xfer) begin
                  state_nxt = ST_EMPTY;
               end
`else
               if (in_xfer) begin
                  load_head = 1'b1;
               end else if (out_xfer) begin
                  state_nxt = ST_EMPTY;
               end
`endif
            end
`ifdef EXMEM_SKID_EN
            ST_FULL: begin
               // ex_ready is low here, so only the drain path applies.
               if (out_xfer) begin
                  head_from_tail = 1'b1;
                  state_nxt      = ST_BUSY;
               end
            end
`endif
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // ---- stage p1: EX/MEM registers ----
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_p1 <= ST_EMPTY;
         head_p1  <= EXMEM_RESET;
      end else begin
         state_p1 <= state_nxt;
         if (load_head) begin
            head_p1 <= in_p0;
`ifdef EXMEM_SKID_EN
         end else if (head_from_tail) begin
            head_p1 <= tail_p1;
`endif
         end
      end
   end

`ifdef EXMEM_SKID_EN
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         tail_p1 <= EXMEM_RESET;
      end else if (load_tail) begin
         tail_p1 <= in_p0;
      end
   end
`endif

   // Side-effecting controls are masked so an empty stage never acts.
   assign mem_load       = head_p1.load  && mem_valid;
   assign mem_store      = head_p1.store && mem_valid;
   assign mem_rd_we      = head_p1.rd_we && mem_valid;
   assign mem_ls_sel     = head_p1.ls_sel;
   assign mem_dest_sel   = head_p1.dest_sel;
   assign mem_rd_addr    = head_p1.rd_addr;
   assign mem_store_data = head_p1.store_data;
   assign mem_pc         = head_p1.pc;
   assign mem_wdata      = head_p1.wdata;
   assign mem_dm_addr    = head_p1.wdata;

endmodule

// File: tb/tb_pipe_exmem_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_exmem_elastic
// Directed checks of pipe_exmem_elastic followed by a random valid/ready
// stream against an in-order scoreboard. Expectations follow EXMEM_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_exmem_elastic;
   import loopyV_data_types::*;

   localparam int unsigned XLEN = 32;
`ifdef EXMEM_SKID_EN
   localparam int unsigned CAP = 2;
`else
   localparam int unsigned CAP = 1;
`endif

   logic            clk;
   logic            arstn;
   logic            flush;
   logic            ex_valid;
   logic            ex_ready;
   logic            ex_load;
   logic            ex_store;
   logic            ex_rd_we;
   logic [2:0]      ex_ls_sel;
   logic [1:0]      ex_dest_sel;
   logic            ex_compressed;
   logic [XLEN-1:0] ex_alu;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] ex_store_data;
   logic [XLEN-1:0] ex_pc;
   logic [4:0]      ex_rd_addr;
   logic            mem_valid;
   logic            mem_ready;
   logic            mem_load;
   logic            mem_store;
   logic            mem_rd_we;
   logic [2:0]      mem_ls_sel;
   logic [1:0]      mem_dest_sel;
   logic [4:0]      mem_rd_addr;
   logic [XLEN-1:0] mem_store_data;
   logic [XLEN-1:0] mem_pc;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_dm_addr;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   pipe_exmem_elastic #(.XLEN(XLEN), .PC_STEP_C(2)) dut (
      .clk            (clk),
      .arstn          (arstn),
      .flush          (flush),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_load        (ex_load),
      .ex_store       (ex_store),
      .ex_rd_we       (ex_rd_we),
      .ex_ls_sel      (ex_ls_sel),
      .ex_dest_sel    (ex_dest_sel),
      .ex_compressed  (ex_compressed),
      .ex_alu         (ex_alu),
      .ex_imm         (ex_imm),
      .ex_store_data  (ex_store_data),
      .ex_pc          (ex_pc),
      .ex_rd_addr     (ex_rd_addr),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_load       (mem_load),
      .mem_store      (mem_store),
      .mem_rd_we      (mem_rd_we),
      .mem_ls_sel     (mem_ls_sel),
      .mem_dest_sel   (mem_dest_sel),
      .mem_rd_addr    (mem_rd_addr),
      .mem_store_data (mem_store_data),
      .mem_pc         (mem_pc),
      .mem_wdata      (mem_wdata),
      .mem_dm_addr    (mem_dm_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] dest, input logic [31:0] alu, input logic [31:0] imm,
                        input logic [31:0] pc, input logic comp, input logic ld, input logic st,
                        input logic we, input logic [4:0] rd, input logic [31:0] sdata);
      ex_valid      = 1'b1;
      ex_dest_sel   = dest;
      ex_alu        = alu;
      ex_imm        = imm;
      ex_pc         = pc;
      ex_compressed = comp;
      ex_load       = ld;
      ex_store      = st;
      ex_rd_we      = we;
      ex_rd_addr    = rd;
      ex_store_data = sdata;
      ex_ls_sel     = FUNCT3_WORD;
   endtask

   task automatic idle();
      ex_valid = 1'b0;
      ex_load  = 1'b0;
      ex_store = 1'b0;
      ex_rd_we = 1'b0;
   endtask

   function automatic logic [31:0] model_wdata(input logic [1:0] dest, input logic [31:0] alu,
                                                input logic [31:0] imm, input logic [31:0] pc,
                                                input logic comp);
      case (dest)
         2'd1:    return imm;
         2'd2:    return pc + (comp ? 32'd2 : 32'd4);
         default: return alu;
      endcase
   endfunction

   initial begin
      logic [36:0] q[$];
      logic [36:0] exp_beat;
      logic [36:0] got_beat;
      logic [1:0]  r_dest;
      logic [31:0] r_alu, r_imm, r_pc;
      logic        r_comp;
      logic [4:0]  r_rd;
      logic        holding;
      logic        in_f, out_f;
      int          sent, got, cyc, maxocc, track_err;

      arstn = 1'b0;
      flush = 1'b0;
      mem_ready = 1'b0;
      offer(WB_SEL_ALU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      idle();

      // reset state
      #12;
      check("rst_mem_valid", mem_valid, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_pc", mem_pc, 0);
      check("rst_ls_sel", mem_ls_sel, FUNCT3_BYTE);
      check("rst_dest_sel", mem_dest_sel, WB_SEL_ALU);
      check("rst_ex_ready", ex_ready, 1);
      arstn = 1'b1;
      step();

      // single ALU beat, one-cycle latency
      mem_ready = 1'b1;
      offer(WB_SEL_ALU, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0);
      step();
      idle();
      check("alu_valid", mem_valid, 1);
      check("alu_wdata", mem_wdata, 32'h0000_1234);
      check("alu_dm_addr", mem_dm_addr, 32'h0000_1234);
      check("alu_rd_we", mem_rd_we, 1);
      check("alu_rd_addr", mem_rd_addr, 5'd7);
      step();
      check("alu_drained", mem_valid, 0);
      check("alu_rd_we_gated", mem_rd_we, 0);

      // PC step variants
      offer(WB_SEL_PC_STEP, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0);
      step(); idle();
      check("pc_step_c", mem_wdata, 32'h0000_0102);
      step();
      offer(WB_SEL_PC_STEP, 32'h0, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0);
      step(); idle();
      check("pc_step_4", mem_wdata, 32'h0000_0104);
      step();
      offer(WB_SEL_PC_STEP, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0);
      step(); idle();
      check("pc_step_wrap", mem_wdata, 32'h0000_0000);
      check("pc_passthru", mem_pc, 32'hFFFF_FFFE);
      step();

      // IMM and MEM sources
      offer(WB_SEL_IMM, 32'h1111_1111, 32'hCAFE_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0);
      step(); idle();
      check("imm_wdata", mem_wdata, 32'hCAFE_0000);
      step();
      offer(WB_SEL_MEM, 32'h0000_0080, 32'h2222_2222, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
      step(); idle();
      check("mem_wdata", mem_wdata, 32'h0000_0080);
      check("mem_load", mem_load, 1);
      check("mem_ls_sel", mem_ls_sel, FUNCT3_WORD);
      check("mem_dest_sel", mem_dest_sel, WB_SEL_MEM);
      check("mem_store_data", mem_store_data, 32'hDEAD_BEEF);
      step();
      check("mem_load_gated", mem_load, 0);

      // back-pressure with beats A, B, C
      mem_ready = 1'b0;
`ifdef EXMEM_SKID_EN
      offer(WB_SEL_ALU, 32'hA, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0);
      step();
      offer(WB_SEL_ALU, 32'hB, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0);
      check("bp_ready_busy", ex_ready, 1);
      step();
      offer(WB_SEL_ALU, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0);
      check("bp_ready_full", ex_ready, 0);
      check("bp_hold_a1", mem_wdata, 32'hA);
      step();
      check("bp_hold_a2", mem_wdata, 32'hA);
      check("bp_hold_rd", mem_rd_addr, 5'd10);
      mem_ready = 1'b1;
      step();
      check("bp_out_b", mem_wdata, 32'hB);
      check("bp_ready_again", ex_ready, 1);
      step();
      idle();
      check("bp_out_c", mem_wdata, 32'hC);
      step();
      check("bp_empty", mem_valid, 0);
`else
      offer(WB_SEL_ALU, 32'hA, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0);
      step();
      offer(WB_SEL_ALU, 32'hB, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0);
      check("bp_ready_stall", ex_ready, 0);
      step();
      check("bp_hold_a1", mem_wdata, 32'hA);
      step();
      check("bp_hold_a2", mem_wdata, 32'hA);
      check("bp_hold_rd", mem_rd_addr, 5'd10);
      mem_ready = 1'b1;
      #1;
      check("bp_ready_comb", ex_ready, 1);
      step();
      check("bp_out_b", mem_wdata, 32'hB);
      offer(WB_SEL_ALU, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0);
      step();
      idle();
      check("bp_out_c", mem_wdata, 32'hC);
      step();
      check("bp_empty", mem_valid, 0);
`endif

      // flush with an incoming beat
      mem_ready = 1'b0;
      offer(WB_SEL_ALU, 32'h0000_00AA, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h55);
      step();
      check("fl_store_before", mem_store, 1);
`ifdef EXMEM_SKID_EN
      offer(WB_SEL_ALU, 32'h0000_00BB, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0);
      step();
      offer(WB_SEL_ALU, 32'h0000_00CC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h66);
      flush = 1'b1;
      check("fl_ready_full", ex_ready, 0);
`else
      mem_ready = 1'b1;
      offer(WB_SEL_ALU, 32'h0000_00CC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h66);
      flush = 1'b1;
      #1;
      check("fl_ready_normal", ex_ready, 1);
`endif
      step();
      flush = 1'b0;
      idle();
      check("fl_valid", mem_valid, 0);
      check("fl_store", mem_store, 0);
      mem_ready = 1'b1;
      step();
      check("fl_no_ghost", mem_valid, 0);

      // asynchronous reset while BUSY
      mem_ready = 1'b0;
      offer(WB_SEL_ALU, 32'h0000_5555, 32'h0, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0);
      step();
      idle();
      check("ar_busy", mem_valid, 1);
      #2;
      arstn = 1'b0;
      #1;
      check("ar_valid", mem_valid, 0);
      check("ar_wdata", mem_wdata, 0);
      check("ar_rd_we", mem_rd_we, 0);
      check("ar_pc", mem_pc, 0);
      check("ar_rd_addr", mem_rd_addr, 0);
      @(posedge clk);
      #2;
      arstn = 1'b1;
      mem_ready = 1'b1;
      step();
      check("ar_no_stale", mem_valid, 0);
      check("ar_ready", ex_ready, 1);

      // random stream against scoreboard
      sent = 0; got = 0; cyc = 0; maxocc = 0; track_err = 0;
      holding = 1'b0;
      r_dest = 2'd0; r_alu = 32'h0; r_imm = 32'h0; r_pc = 32'h0; r_comp = 1'b0; r_rd = 5'd0;
      while (got < 1000 && cyc < 20000) begin
         if (!holding && sent < 1000 && $urandom_range(0, 9) < 7) begin
            r_dest = 2'($urandom_range(0, 3));
            r_alu  = $urandom;
            r_imm  = $urandom;
            r_pc   = $urandom;
            r_comp = 1'($urandom_range(0, 1));
            r_rd   = 5'($urandom_range(0, 31));
            offer(r_dest, r_alu, r_imm, r_pc, r_comp, 1'b0, 1'b0, 1'b1, r_rd, 32'h0);
            holding = 1'b1;
         end
         if (!holding) idle();
         mem_ready = ($urandom_range(0, 3) != 0);
         #1;
         in_f  = ex_valid && ex_ready;
         out_f = mem_valid && mem_ready;
         if (out_f) begin
            got_beat = {mem_rd_addr, mem_wdata};
            if (q.size() == 0) begin
               check("stream_unexpected_beat", got_beat, 37'h0);
            end else begin
               exp_beat = q.pop_front();
               check("stream_beat", got_beat, exp_beat);
            end
            got++;
         end
         if (in_f) begin
            q.push_back({r_rd, model_wdata(r_dest, r_alu, r_imm, r_pc, r_comp)});
            sent++;
            holding = 1'b0;
         end
         if (q.size() > maxocc) maxocc = q.size();
         step();
         if (mem_valid !== (q.size() != 0)) track_err++;
         cyc++;
      end
      idle();
      check("stream_count", got, 1000);
      check("stream_occupancy_cap", (maxocc <= CAP), 1);
      check("stream_valid_tracking", track_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
